mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/arb_wdog.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types and defaults for the memory port arbiter: FSM state
// encoding, access owner encoding and the default watchdog limit.
package riscv_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY_IF = 3'd1,
    BUSY_D  = 3'd2,
    RESP_IF = 3'd3,
    RESP_D  = 3'd4
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  localparam int unsigned ARB_TIMEOUT_DEFAULT = 32'd15;

  function automatic logic arb_is_busy(input arb_state_t s);
    return (s == BUSY_IF) || (s == BUSY_D);
  endfunction

endpackage

// File: rtl/arb_wdog.sv
// Busy-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle on which the count reaches TIMEOUT.
module arb_wdog
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 32'd1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 32'd1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counter next state; holds at LAST so it can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The TIMEOUT-th enabled cycle is the one where the count still reads LAST.
  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one single-port memory.
// Optional macro MEM_ARB_RR_EN enables round-robin on ties (default: data wins).
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = ARB_TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_ack,
  output logic                  stall,
  output logic                  err
);

  arb_state_t            state_q,    state_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic                  we_q,       we_d;
  logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q,  d_rdata_d;
  logic                  err_q,      err_d;
  logic                  pick_d;
  logic                  busy;
  logic                  expired;
`ifdef MEM_ARB_RR_EN
  arb_owner_t            last_grant_q, last_grant_d;
`endif

  assign busy = arb_is_busy(state_q);

  arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (~busy),
    .en      (busy),
    .expired (expired)
  );

  // Grant decision for the IDLE state.
  always_comb begin
    pick_d = 1'b0;
`ifdef MEM_ARB_RR_EN
    if (d_req && if_req) begin
      pick_d = (last_grant_q == OWN_IF);
    end else begin
      pick_d = d_req;
    end
`else
    pick_d = d_req;
`endif
  end

  // FSM next state plus the latched access and response data.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    err_d      = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (d_req || if_req) begin
          if (pick_d) begin
            state_d = BUSY_D;
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
`ifdef MEM_ARB_RR_EN
            last_grant_d = OWN_D;
`endif
          end else begin
            state_d = BUSY_IF;
            addr_d  = if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
`ifdef MEM_ARB_RR_EN
            last_grant_d = OWN_IF;
`endif
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_IF: begin
        if (m_ack) begin
          if_rdata_d = m_rdata;
          state_d    = RESP_IF;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = RESP_IF;
        end else begin
          state_d = BUSY_IF;
        end
      end
      BUSY_D: begin
        if (m_ack) begin
          // Stores leave the load data register untouched.
          if (!we_q) begin
            d_rdata_d = m_rdata;
          end else begin
            d_rdata_d = d_rdata_q;
          end
          state_d = RESP_D;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = RESP_D;
        end else begin
          state_d = BUSY_D;
        end
      end
      RESP_IF: state_d = IDLE;
      RESP_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      err_q      <= err_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Last served requester; starts at fetch so data wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= OWN_IF;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
`endif

  assign m_req    = busy;
  assign m_we     = we_q & busy;
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_ready = (state_q == RESP_IF);
  assign d_ready  = (state_q == RESP_D);
  assign err      = err_q;
  assign stall    = (if_req & ~if_ready) | (d_req & ~d_ready);

endmodule
